// File: rtl/tetromino_pkg.sv
// Shared types and LFSR tap masks for the tetromino sequencer.
package tetromino_pkg;

    localparam int NUM_PIECES = 7;

    typedef logic [2:0] piece_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } draw_state_e;

    // The register shifts right, so each exponent e < W of x^W + ... + 1 taps bit W-e,
    // and bit 0 closes the loop. This runs the reciprocal polynomial, which is also primitive.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] mask;
        mask = 32'h0000_0000;
        case (width)
            15:      mask = 32'h0000_0003;
            16:      mask = 32'h0000_100B;
            23:      mask = 32'h0000_0021;
            31:      mask = 32'h0000_0009;
            default: mask = 32'h0000_0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci LFSR with seed load and zero-lock recovery; exposes the low three bits as the piece candidate.
module prbs_lfsr
    import tetromino_pkg::*;
#(
    parameter int                    LFSR_WIDTH   = 15,
    parameter logic [LFSR_WIDTH-1:0] SEED_DEFAULT = '1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_seed_load,
    input  logic [LFSR_WIDTH-1:0] i_seed,
    output piece_t                o_cand
);
    localparam logic [LFSR_WIDTH-1:0] TAPS = LFSR_WIDTH'(lfsr_taps(LFSR_WIDTH));

    logic [LFSR_WIDTH-1:0] r_state;
    logic                  w_feedback;

    assign w_feedback = ^(r_state & TAPS);

    // A zero seed would lock the register, so it is replaced by all ones.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= SEED_DEFAULT;
        end else if (i_seed_load) begin
            r_state <= (i_seed == '0) ? '1 : i_seed;
        end else if (r_state == '0) begin
            r_state <= '1;
        end else begin
            r_state <= {w_feedback, r_state[LFSR_WIDTH-1:1]};
        end
    end

    assign o_cand = r_state[2:0];

endmodule

// File: rtl/tetromino_bag_gen.sv
// Tetromino sequencer: LFSR rejection sampler feeding a preview shift-queue popped by valid/ready.
// Define TETRO_BAG_EN for 7-bag fairness; left undefined, pieces are drawn uniformly.
module tetromino_bag_gen
    import tetromino_pkg::*;
#(
    parameter int                    LFSR_WIDTH    = 15,
    parameter logic [LFSR_WIDTH-1:0] SEED_DEFAULT  = '1,
    parameter int                    PREVIEW_DEPTH = 4,
    parameter int                    ROT_BITS      = 2,
    parameter int                    MEM_AWIDTH    = 5,
    parameter int                    MAX_REJECT    = 15
) (
    input  logic                               i_pixclk,
    input  logic                               i_reset,
    input  logic                               i_seed_load,
    input  logic [LFSR_WIDTH-1:0]              i_seed,
    input  logic                               i_ready,
    output logic                               o_valid,
    output logic [2:0]                         o_piece,
    output logic [MEM_AWIDTH-1:0]              o_random_address,
    output logic [3*PREVIEW_DEPTH-1:0]         o_preview,
    output logic [$clog2(PREVIEW_DEPTH+1)-1:0] o_count
);
    localparam int               CNT_W        = $clog2(PREVIEW_DEPTH + 1);
    localparam int               REJ_W        = $clog2(MAX_REJECT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(PREVIEW_DEPTH);
    localparam logic [REJ_W-1:0] REJECT_LIMIT = REJ_W'(MAX_REJECT);

    piece_t                       w_cand;
    piece_t                       w_fallback;
    piece_t                       w_pushPiece;
    piece_t [PREVIEW_DEPTH-1:0]   r_queue;
    piece_t [PREVIEW_DEPTH-1:0]   w_queueNext;
    logic   [CNT_W-1:0]           r_count;
    logic   [CNT_W-1:0]           w_countNext;
    logic   [CNT_W-1:0]           w_slot;
    logic   [REJ_W-1:0]           r_reject;
    logic   [REJ_W-1:0]           w_rejectNext;
    draw_state_e                  r_state;
    draw_state_e                  w_stateNext;
    logic                         w_drawEn;
    logic                         w_candOk;
    logic                         w_forced;
    logic                         w_push;
    logic                         w_pop;
`ifdef TETRO_BAG_EN
    logic   [NUM_PIECES-1:0]      r_bagUsed;
    logic   [NUM_PIECES-1:0]      w_bagSet;
    logic   [NUM_PIECES-1:0]      w_bagNext;
    logic   [7:0]                 w_bagBlocked;
`endif

    prbs_lfsr #(
        .LFSR_WIDTH   (LFSR_WIDTH),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_lfsr (
        .i_clk       (i_pixclk),
        .i_reset     (i_reset),
        .i_seed_load (i_seed_load),
        .i_seed      (i_seed),
        .o_cand      (w_cand)
    );

    // Sampler: piece ID 7 is treated as permanently used so one lookup covers both rejections.
    always_comb begin
        w_pop    = (r_count != '0) && i_ready;
        w_drawEn = (r_state == ST_FILL) && !i_seed_load && (r_count < DEPTH_C);
        w_forced = (r_reject == REJECT_LIMIT);
`ifdef TETRO_BAG_EN
        w_bagBlocked = {1'b1, r_bagUsed};
        w_candOk     = !w_bagBlocked[w_cand];
        w_fallback   = '0;
        for (int i = NUM_PIECES - 1; i >= 0; i--) begin
            if (!r_bagUsed[i]) begin
                w_fallback = piece_t'(i);
            end
        end
`else
        w_candOk   = (w_cand != 3'd7);
        w_fallback = '0;
`endif
        w_push      = w_drawEn && (w_forced || w_candOk);
        w_pushPiece = w_forced ? w_fallback : w_cand;
    end

    // On a simultaneous pop the new piece lands one slot lower, in the last occupied slot.
    always_comb begin
        w_queueNext = r_queue;
        w_countNext = r_count;
        w_slot      = r_count;
        if (w_pop) begin
            w_queueNext = {piece_t'(0), r_queue[PREVIEW_DEPTH-1:1]};
            w_countNext = r_count - 1'b1;
            w_slot      = r_count - 1'b1;
        end
        for (int i = 0; i < PREVIEW_DEPTH; i++) begin
            if (w_push && (w_slot == CNT_W'(i))) begin
                w_queueNext[i] = w_pushPiece;
            end
        end
        if (w_push) begin
            w_countNext = w_countNext + 1'b1;
        end
    end

    always_comb begin
        w_rejectNext = r_reject;
        if (w_push) begin
            w_rejectNext = '0;
        end else if (w_drawEn) begin
            w_rejectNext = r_reject + 1'b1;
        end
        w_stateNext = r_state;
        case (r_state)
            ST_FILL: if (w_countNext == DEPTH_C) w_stateNext = ST_FULL;
            ST_FULL: if (w_pop) w_stateNext = ST_FILL;
            default: w_stateNext = ST_FILL;
        endcase
    end

    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            r_queue  <= '0;
            r_count  <= '0;
            r_reject <= '0;
            r_state  <= ST_FILL;
        end else begin
            r_queue  <= w_queueNext;
            r_count  <= w_countNext;
            r_reject <= w_rejectNext;
            r_state  <= w_stateNext;
        end
    end

`ifdef TETRO_BAG_EN
    // A completed bag clears on the same edge as its seventh push.
    always_comb begin
        w_bagSet  = r_bagUsed | (NUM_PIECES'(1) << w_pushPiece);
        w_bagNext = r_bagUsed;
        if (w_push) begin
            w_bagNext = (w_bagSet == '1) ? '0 : w_bagSet;
        end
    end

    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            r_bagUsed <= '0;
        end else begin
            r_bagUsed <= w_bagNext;
        end
    end
`endif

    assign o_valid          = (r_count != '0);
    assign o_piece          = r_queue[0];
    assign o_random_address = MEM_AWIDTH'({r_queue[0], {ROT_BITS{1'b0}}});
    assign o_preview        = r_queue;
    assign o_count          = r_count;

endmodule
